// File: rtl/tmp_readout.sv
// tmp_readout: receiving end of the temperature-sensor comparator bitstream.
//
// After a start pulse the first SETTLE comparator samples are discarded, then
// the ones over a 2^NBITS-sample window are counted. The count is presented as
// a code word through a valid/ready handshake.
//
// Optional build macro: TMP_READOUT_OFFSET_CAL_EN
//   When defined, the signed offset ofs is added to the ones count and the sum
//   is saturated to [0, 2^NBITS]. Otherwise ofs is ignored and code is the raw count.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle pulse, begins a conversion when idle
//   abort        level, returns to IDLE and discards the partial result
//   cont         continuous mode: the next window starts immediately at window end
//   smpl_vld     one-cycle strobe per comparator sample
//   smpl_bit     comparator decision, qualified by smpl_vld
//   ofs          signed offset (offset-calibration build only)
//   code         result, 0..2^NBITS
//   code_valid   result available
//   rd_ready     host accepts code when code_valid && rd_ready
//   busy         conversion in progress (SETTLE or ACCUM)
//   overrun      sticky, a completed result was dropped; cleared by start
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | waiting for start, samples ignored
// ST_SETTLE | discarding the leading settling samples
// ST_ACCUM  | counting ones over the conversion window

module tmp_readout #(
    parameter int NBITS  = 10,
    parameter int SETTLE = 4,
    parameter int OFS_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cont,
    input  logic                    smpl_vld,
    input  logic                    smpl_bit,
    input  logic signed [OFS_W-1:0] ofs,
    output logic        [NBITS:0]   code,
    output logic                    code_valid,
    input  logic                    rd_ready,
    output logic                    busy,
    output logic                    overrun
);

    localparam int CW = NBITS + 1;
    // Width holds SETTLE-1 (and stays at least one bit when SETTLE is 0).
    localparam int SW = $clog2(SETTLE + 2);
    localparam logic [CW-1:0] LAST = {1'b0, {NBITS{1'b1}}};
    localparam logic [CW-1:0] FULL = {1'b1, {NBITS{1'b0}}};
    localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM
    } state_t;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [CW-1:0] smpl_cnt;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] ones_next;
    logic [CW-1:0] result;
    logic          win_done;

    // The completing strobe's own bit is part of the final count.
    always_comb begin
        ones_next = ones_cnt + {{NBITS{1'b0}}, smpl_bit};
        win_done  = (state == ST_ACCUM) && smpl_vld && !abort && (smpl_cnt == LAST);
    end

`ifdef TMP_READOUT_OFFSET_CAL_EN
    // One guard bit above the wider operand plus a sign bit, so the sum never wraps.
    localparam int SUM_W = (((NBITS + 2) > (OFS_W + 1)) ? (NBITS + 2) : (OFS_W + 1)) + 1;
    localparam logic signed [SUM_W-1:0] FULL_S = SUM_W'(FULL);
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        sum = signed'(SUM_W'(ones_next)) + SUM_W'(ofs);
        if (sum[SUM_W-1]) begin
            result = '0;
        end else if (sum > FULL_S) begin
            result = FULL;
        end else begin
            result = sum[CW-1:0];
        end
    end
`else
    logic unused_ofs;
    assign unused_ofs = ^ofs;
    assign result     = ones_next;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            smpl_cnt   <= '0;
            ones_cnt   <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Output side: a transfer clears valid unless a new result lands now.
            if (code_valid && rd_ready) begin
                code_valid <= 1'b0;
            end
            if (win_done) begin
                if (code_valid && !rd_ready) begin
                    overrun <= 1'b1;
                end else begin
                    code       <= result;
                    code_valid <= 1'b1;
                end
            end

            if (abort) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                smpl_cnt <= '0;
                ones_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            overrun  <= 1'b0;
                            busy     <= 1'b1;
                            smpl_cnt <= '0;
                            ones_cnt <= '0;
                            if (SETTLE == 0) begin
                                state <= ST_ACCUM;
                            end else begin
                                state      <= ST_SETTLE;
                                settle_cnt <= SETTLE_LOAD;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (smpl_vld) begin
                            if (settle_cnt == '0) begin
                                state <= ST_ACCUM;
                            end else begin
                                settle_cnt <= settle_cnt - SW'(1);
                            end
                        end
                    end
                    ST_ACCUM: begin
                        if (smpl_vld) begin
                            if (smpl_cnt == LAST) begin
                                smpl_cnt <= '0;
                                ones_cnt <= '0;
                                if (!cont) begin
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                smpl_cnt <= smpl_cnt + CW'(1);
                                ones_cnt <= ones_next;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tmp_readout.sv
// tb_tmp_readout: directed bench for tmp_readout with NBITS=4, SETTLE=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_tmp_readout;

    localparam int NBITS  = 4;
    localparam int SETTLE = 2;
    localparam int OFS_W  = 8;

    logic                    clk      = 1'b0;
    logic                    reset_n  = 1'b0;
    logic                    start    = 1'b0;
    logic                    abort    = 1'b0;
    logic                    cont     = 1'b0;
    logic                    smpl_vld = 1'b0;
    logic                    smpl_bit = 1'b0;
    logic                    rd_ready = 1'b0;
    logic signed [OFS_W-1:0] ofs      = '0;
    logic        [NBITS:0]   code;
    logic                    code_valid;
    logic                    busy;
    logic                    overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tmp_readout #(
        .NBITS (NBITS),
        .SETTLE(SETTLE),
        .OFS_W (OFS_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .cont      (cont),
        .smpl_vld  (smpl_vld),
        .smpl_bit  (smpl_bit),
        .ofs       (ofs),
        .code      (code),
        .code_valid(code_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    task automatic pulse_ready();
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    task automatic strobes(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            smpl_vld = 1'b1;
            smpl_bit = b;
            tick(1);
            smpl_vld = 1'b0;
            smpl_bit = 1'b0;
        end
    endtask

    initial begin
        tick(2);
        check("rst_code", code, 0);
        check("rst_valid", code_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        tick(1);

        // All-ones window: settle strobes dropped, full count with no wrap.
        pulse_start();
        check("t1_busy", busy, 1);
        strobes(17, 1'b1);
        check("t1_valid_early", code_valid, 0);
        strobes(1, 1'b1);
        check("t1_code", code, 16);
        check("t1_valid", code_valid, 1);
        check("t1_busy_fall", busy, 0);
        pulse_ready();
        check("t1_valid_clr", code_valid, 0);

        // Alternating pattern, then host stall holds the result.
        pulse_start();
        strobes(2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            strobes(1, 1'b1);
            strobes(1, 1'b0);
        end
        check("t2_code", code, 8);
        tick(10);
        check("t2_code_hold", code, 8);
        check("t2_valid_hold", code_valid, 1);
        pulse_ready();
        check("t2_valid_clr", code_valid, 0);

        // Continuous mode with stalled host: second result dropped.
        cont = 1'b1;
        pulse_start();
        strobes(2, 1'b0);
        strobes(16, 1'b0);
        check("t3_code0", code, 0);
        check("t3_valid0", code_valid, 1);
        check("t3_ovr0", overrun, 0);
        strobes(16, 1'b1);
        check("t3_code_kept", code, 0);
        check("t3_ovr1", overrun, 1);
        check("t3_busy_cont", busy, 1);
        cont = 1'b0;
        pulse_abort();
        check("t3_abort_busy", busy, 0);
        check("t3_abort_ovr", overrun, 1);
        check("t3_abort_valid", code_valid, 1);
        pulse_start();
        check("t3_start_clr_ovr", overrun, 0);
        pulse_abort();
        pulse_ready();
        check("t3_valid_clr", code_valid, 0);

        // Continuous mode with ready host: two results, no overrun.
        rd_ready = 1'b1;
        cont     = 1'b1;
        pulse_start();
        strobes(2, 1'b1);
        strobes(4, 1'b1);
        strobes(12, 1'b0);
        check("t4_code4", code, 4);
        check("t4_valid4", code_valid, 1);
        strobes(12, 1'b1);
        strobes(3, 1'b0);
        check("t4_valid_taken", code_valid, 0);
        strobes(1, 1'b0);
        check("t4_code12", code, 12);
        check("t4_valid12", code_valid, 1);
        check("t4_ovr", overrun, 0);
        cont = 1'b0;
        pulse_abort();
        check("t4_valid_clr", code_valid, 0);
        rd_ready = 1'b0;

        // Abort mid-window discards the partial count.
        pulse_start();
        strobes(2, 1'b1);
        strobes(7, 1'b1);
        pulse_abort();
        check("t5_abort_busy", busy, 0);
        tick(3);
        check("t5_no_result", code_valid, 0);
        pulse_start();
        strobes(18, 1'b0);
        check("t5_code", code, 0);
        check("t5_valid", code_valid, 1);
        pulse_ready();

        // Asynchronous reset between edges during ACCUM.
        pulse_start();
        strobes(18, 1'b1);
        check("t6_code16", code, 16);
        pulse_start();
        strobes(7, 1'b1);
        check("t6_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_code", code, 0);
        check("t6_rst_valid", code_valid, 0);
        check("t6_rst_busy", busy, 0);
        tick(1);
        reset_n = 1'b1;
        strobes(10, 1'b1);
        check("t6_no_partial", code_valid, 0);
        check("t6_idle", busy, 0);

`ifdef TMP_READOUT_OFFSET_CAL_EN
        // Offset calibration: saturation at both ends.
        ofs = -8'sd3;
        pulse_start();
        strobes(2, 1'b1);
        strobes(2, 1'b1);
        strobes(14, 1'b0);
        check("t7_sat_low", code, 0);
        check("t7_valid", code_valid, 1);
        pulse_ready();
        ofs = 8'sd5;
        pulse_start();
        strobes(2, 1'b0);
        strobes(14, 1'b1);
        strobes(2, 1'b0);
        check("t7_sat_high", code, 16);
        pulse_ready();
        ofs = 8'sd2;
        pulse_start();
        strobes(2, 1'b0);
        strobes(5, 1'b1);
        strobes(11, 1'b0);
        check("t7_mid", code, 7);
        pulse_ready();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmp_readout.md
Name: tmp_readout

Overview:
- Receiving end of the temperature-sensor comparator bitstream.
- Takes sampled comparator decisions (strobe plus bit) from the sensor controller and discards a programmable number of settling samples.
- Counts the ones over a 2^NBITS-sample window and presents the result as a code word to the host through a valid/ready handshake.
- Sits between the sensor controller and the digital register/readout interface.

Parameters:
- NBITS, 10, log2 of conversion window length in samples (window = 2^NBITS).
- SETTLE, 4, number of leading samples discarded after start (0 allowed).
- OFS_W, 8, width of signed offset input (only used with OFFSET_CAL_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a conversion when idle.
- abort  input  1  level; while high, forces return to IDLE and discards the partial result.
- cont  input  1  continuous mode; when high at window end, next conversion starts immediately (SETTLE skipped).
- smpl_vld  input  1  strobe, one cycle per comparator sample.
- smpl_bit  input  1  comparator decision qualified by smpl_vld.
- ofs  input  OFS_W  signed offset added to the result (OFFSET_CAL_EN only).
- code  output  NBITS+1  result, range 0..2^NBITS.
- code_valid  output  1  result available.
- rd_ready  input  1  host accepts code when code_valid&&rd_ready.
- busy  output  1  high in SETTLE or ACCUM.
- overrun  output  1  sticky: a completed result was dropped.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, code=0, code_valid=0, busy=0, overrun=0, counters=0.
- States: IDLE, SETTLE, ACCUM.
- IDLE:
  - start=1 -> SETTLE, or ACCUM if SETTLE==0.
  - start also clears overrun.
  - smpl_vld is ignored in IDLE.
- SETTLE: count smpl_vld strobes; on the SETTLE-th strobe -> ACCUM. Bits are discarded.
- ACCUM:
  - On each smpl_vld, sample counter +1 and ones counter +smpl_bit.
  - On the 2^NBITS-th strobe the window completes. The final ones count includes that strobe's bit.
- Window completion, in the same cycle:
  - Result = ones count.
  - If cont=1, go to ACCUM with counters cleared. Otherwise go to IDLE.
- Result load, registered: code/code_valid update on the edge following the completing strobe (latency 1 cycle).
- Handshake:
  - code and code_valid are stable while code_valid=1 && rd_ready=0.
  - Transfer occurs on a cycle with code_valid&&rd_ready; code_valid then clears unless a new result loads the same cycle.
- Collision cases:
  - New result while code_valid=1 and rd_ready=0: new result is dropped, old code kept, overrun<=1.
  - New result with code_valid=1 and rd_ready=1 in the same cycle: old transferred, new loaded, code_valid stays 1, no overrun.
- busy: 1 in SETTLE and ACCUM, 0 in IDLE.
- start while busy is ignored.
- abort:
  - abort=1 has priority over start and smpl_vld.
  - Next state is IDLE and counters clear.
  - code, code_valid and overrun are untouched.
- Counter widths: sample counter NBITS+1 bits, ones counter NBITS+1 bits. All-ones window yields 2^NBITS with no wrap.
- Async reset mid-conversion: immediate return to reset values; no partial result emitted.

Optional Feature:
- Macro: TMP_READOUT_OFFSET_CAL_EN.
- Defined:
  - code = ones + sign-extended ofs, saturated to [0, 2^NBITS].
  - The addition is registered with the result, so latency is unchanged.
- Undefined:
  - ofs is unused, and code is the raw ones count.

Test Plan (NBITS=4, SETTLE=2):
- Reset, start, 18 strobes with bit=1 -> first 2 ignored; code=16, code_valid=1 one cycle after the 18th strobe; busy falls; state IDLE.
- Start, 2 settle strobes, then an alternating 1,0 pattern over 16 strobes -> code=8. Hold rd_ready=0 for 10 cycles -> code stays 8 and valid stays 1. Pulse rd_ready -> code_valid=0 next cycle.
- cont=1, rd_ready=0, two windows of all-0 then all-1 -> first code=0 kept, overrun=1 after the second window; next start clears overrun.
- cont=1, rd_ready=1 held, two windows of 4 ones then 12 ones -> code sequence 4, 12 with code_valid continuously high at the second load, overrun=0.
- abort after 7 ACCUM strobes, then start plus 18 strobes of all-0 -> no result from the aborted run; code=0 from the new run.
- Assert reset_n=0 mid-ACCUM, asynchronously between clock edges -> outputs reset immediately; with OFFSET_CAL_EN and ofs=-3 on 2 ones -> code=0 (saturated); ofs=+5 on 14 ones -> code=16.
